video_timing_gen_prog: RTL and testbench

Parametrised, runtime-programmable video timing generator for the HDMI/display path. It produces pixel/line counters, polarity-configurable sync strobes, an active-display flag, a new-frame strobe and a frame counter. Timing geometry can be reprogrammed through a valid/ready config port, with the change applied only at a frame boundary. An optional genlock input snaps the raster to an external frame-start pulse, such as a camera frame start, so that stereo capture and display stay frame-aligned.

---
 rtl/video_timing_gen_prog_if.sv | 31 +++
 rtl/video_timing_gen_prog.sv | 229 ++++++++++++++++++++++
 tb/tb_video_timing_gen_prog.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_prog_if.sv
// rtl/video_timing_gen_prog_if.sv - runtime timing configuration bus for video_timing_gen_prog
interface video_timing_gen_prog_if #(
    parameter int H_W = 12,
    parameter int V_W = 11
);
    logic [H_W-1:0] cfg_h_active_in;
    logic [H_W-1:0] cfg_h_fp_in;
    logic [H_W-1:0] cfg_h_sync_in;
    logic [H_W-1:0] cfg_h_bp_in;
    logic [V_W-1:0] cfg_v_active_in;
    logic [V_W-1:0] cfg_v_fp_in;
    logic [V_W-1:0] cfg_v_sync_in;
    logic [V_W-1:0] cfg_v_bp_in;
    logic           cfg_valid_in;
    logic           cfg_ready_out;
    logic           cfg_err_out;

    modport master (
        output cfg_h_active_in, cfg_h_fp_in, cfg_h_sync_in, cfg_h_bp_in,
        output cfg_v_active_in, cfg_v_fp_in, cfg_v_sync_in, cfg_v_bp_in,
        output cfg_valid_in,
        input  cfg_ready_out, cfg_err_out
    );

    modport slave (
        input  cfg_h_active_in, cfg_h_fp_in, cfg_h_sync_in, cfg_h_bp_in,
        input  cfg_v_active_in, cfg_v_fp_in, cfg_v_sync_in, cfg_v_bp_in,
        input  cfg_valid_in,
        output cfg_ready_out, cfg_err_out
    );
endinterface

// File: rtl/video_timing_gen_prog.sv
// rtl/video_timing_gen_prog.sv - programmable video timing generator with frame-boundary reconfig and genlock
module video_timing_gen_prog #(
    parameter int H_W          = 12,
    parameter int V_W          = 11,
    parameter int DEF_H_ACTIVE = 1280,
    parameter int DEF_H_FP     = 110,
    parameter int DEF_H_SYNC   = 40,
    parameter int DEF_H_BP     = 220,
    parameter int DEF_V_ACTIVE = 720,
    parameter int DEF_V_FP     = 5,
    parameter int DEF_V_SYNC   = 5,
    parameter int DEF_V_BP     = 20,
    parameter bit HS_POL       = 1'b1,
    parameter bit VS_POL       = 1'b1,
    parameter int FPS          = 60,
    localparam int FC_W        = (FPS > 1) ? $clog2(FPS) : 1
) (
    input  logic                     pixel_clk_in,
    input  logic                     rst_in,
    video_timing_gen_prog_if.slave   cfg,
    input  logic                     genlock_en_in,
    input  logic                     genlock_in,
    output logic [H_W-1:0]           hcount_out,
    output logic [V_W-1:0]           vcount_out,
    output logic                     hs_out,
    output logic                     vs_out,
    output logic                     ad_out,
    output logic                     nf_out,
    output logic [FC_W-1:0]          fc_out,
    output logic                     lock_out
);

    // Sums are carried two bits wider so a total of exactly 2^W is representable.
    localparam int HX_W = H_W + 2;
    localparam int VX_W = V_W + 2;

    localparam logic [HX_W-1:0] H_LIMIT = HX_W'(1) << H_W;
    localparam logic [VX_W-1:0] V_LIMIT = VX_W'(1) << V_W;

    typedef struct packed {
        logic [H_W-1:0] h_active;
        logic [H_W-1:0] h_fp;
        logic [H_W-1:0] h_sync;
        logic [H_W-1:0] h_bp;
        logic [V_W-1:0] v_active;
        logic [V_W-1:0] v_fp;
        logic [V_W-1:0] v_sync;
        logic [V_W-1:0] v_bp;
    } timing_t;

    localparam timing_t DEF_TIMING = '{
        h_active: H_W'(DEF_H_ACTIVE),
        h_fp:     H_W'(DEF_H_FP),
        h_sync:   H_W'(DEF_H_SYNC),
        h_bp:     H_W'(DEF_H_BP),
        v_active: V_W'(DEF_V_ACTIVE),
        v_fp:     V_W'(DEF_V_FP),
        v_sync:   V_W'(DEF_V_SYNC),
        v_bp:     V_W'(DEF_V_BP)
    };

    function automatic logic [HX_W-1:0] h_total(input timing_t t);
        return HX_W'(t.h_active) + HX_W'(t.h_fp) + HX_W'(t.h_sync) + HX_W'(t.h_bp);
    endfunction

    function automatic logic [VX_W-1:0] v_total(input timing_t t);
        return VX_W'(t.v_active) + VX_W'(t.v_fp) + VX_W'(t.v_sync) + VX_W'(t.v_bp);
    endfunction

    function automatic logic is_legal(input timing_t t);
        return (t.h_active != '0) && (t.h_fp != '0) && (t.h_sync != '0) && (t.h_bp != '0) &&
               (t.v_active != '0) && (t.v_fp != '0) && (t.v_sync != '0) && (t.v_bp != '0) &&
               (h_total(t) <= H_LIMIT) && (v_total(t) <= V_LIMIT);
    endfunction

    timing_t         live_q;
    timing_t         pend_q;
    timing_t         live_d;
    timing_t         cfg_req;
    logic            ready_q;
    logic            err_q;
    logic            accept;
    logic            apply_cfg;
    logic            reject_cfg;

    logic [H_W-1:0]  hcount_q;
    logic [V_W-1:0]  vcount_q;
    logic [H_W-1:0]  hcount_d;
    logic [V_W-1:0]  vcount_d;
    logic [FC_W-1:0] fc_q;
    logic [FC_W-1:0] fc_d;

    logic [HX_W-1:0] htot_q;
    logic [VX_W-1:0] vtot_q;
    logic            h_last;
    logic            v_last;
    logic            at_end;
    logic            gl_pulse;
    logic            wrap;

    logic            hs_d;
    logic            vs_d;
    logic            ad_d;
    logic            nf_d;

    assign cfg_req.h_active = cfg.cfg_h_active_in;
    assign cfg_req.h_fp     = cfg.cfg_h_fp_in;
    assign cfg_req.h_sync   = cfg.cfg_h_sync_in;
    assign cfg_req.h_bp     = cfg.cfg_h_bp_in;
    assign cfg_req.v_active = cfg.cfg_v_active_in;
    assign cfg_req.v_fp     = cfg.cfg_v_fp_in;
    assign cfg_req.v_sync   = cfg.cfg_v_sync_in;
    assign cfg_req.v_bp     = cfg.cfg_v_bp_in;

    assign cfg.cfg_ready_out = ready_q;
    assign cfg.cfg_err_out   = err_q;
    assign hcount_out        = hcount_q;
    assign vcount_out        = vcount_q;
    assign fc_out            = fc_q;

    assign htot_q = h_total(live_q);
    assign vtot_q = v_total(live_q);

    // Frame-boundary decision: natural end of raster or an external genlock pulse,
    // and whether a pending config is committed or rejected on that boundary.
    always_comb begin
        h_last     = (HX_W'(hcount_q) == (htot_q - HX_W'(1)));
        v_last     = (VX_W'(vcount_q) == (vtot_q - VX_W'(1)));
        at_end     = h_last && v_last;
        gl_pulse   = genlock_en_in && genlock_in;
        wrap       = at_end || gl_pulse;
        accept     = cfg.cfg_valid_in && ready_q;
        apply_cfg  = wrap && !ready_q && is_legal(pend_q);
        reject_cfg = wrap && !ready_q && !is_legal(pend_q);
        live_d     = apply_cfg ? pend_q : live_q;
    end

    // Next raster position and frame count; any wrap lands on (0,0).
    always_comb begin
        hcount_d = hcount_q + H_W'(1);
        vcount_d = vcount_q;
        fc_d     = fc_q;
        if (wrap) begin
            hcount_d = '0;
            vcount_d = '0;
            fc_d     = (fc_q == FC_W'(FPS - 1)) ? '0 : fc_q + FC_W'(1);
        end else if (h_last) begin
            hcount_d = '0;
            vcount_d = vcount_q + V_W'(1);
        end
    end

    // Flags are derived from the next position and the geometry that will be live
    // there, so they register alongside the counters with zero latency.
    always_comb begin
        logic [HX_W-1:0] h_ext;
        logic [VX_W-1:0] v_ext;
        logic [HX_W-1:0] hs_start;
        logic [VX_W-1:0] vs_start;
        h_ext    = HX_W'(hcount_d);
        v_ext    = VX_W'(vcount_d);
        hs_start = HX_W'(live_d.h_active) + HX_W'(live_d.h_fp);
        vs_start = VX_W'(live_d.v_active) + VX_W'(live_d.v_fp);
        hs_d     = ((h_ext >= hs_start) && (h_ext < hs_start + HX_W'(live_d.h_sync))) ? HS_POL : ~HS_POL;
        vs_d     = ((v_ext >= vs_start) && (v_ext < vs_start + VX_W'(live_d.v_sync))) ? VS_POL : ~VS_POL;
        ad_d     = (h_ext < HX_W'(live_d.h_active)) && (v_ext < VX_W'(live_d.v_active));
        nf_d     = (hcount_d == live_d.h_active) && (vcount_d == live_d.v_active);
    end

    // Live/pending timing registers and the config handshake.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            live_q  <= DEF_TIMING;
            pend_q  <= DEF_TIMING;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            live_q <= live_d;
            err_q  <= reject_cfg;
            if (wrap && !ready_q) begin
                ready_q <= 1'b1;
            end else if (accept) begin
                pend_q  <= cfg_req;
                ready_q <= 1'b0;
            end
        end
    end

    // Raster counters and frame counter.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            hcount_q <= '0;
            vcount_q <= '0;
            fc_q     <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            fc_q     <= fc_d;
        end
    end

    // Registered sync/active/new-frame flags.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            hs_out <= ~HS_POL;
            vs_out <= ~VS_POL;
            ad_out <= 1'b0;
            nf_out <= 1'b0;
        end else begin
            hs_out <= hs_d;
            vs_out <= vs_d;
            ad_out <= ad_d;
            nf_out <= nf_d;
        end
    end

    // Genlock phase indicator: set when the external pulse coincides with our own
    // frame end, cleared when it forces a wrap or genlock is disabled.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            lock_out <= 1'b0;
        end else if (!genlock_en_in) begin
            lock_out <= 1'b0;
        end else if (genlock_in) begin
            lock_out <= at_end;
        end
    end

endmodule

// File: tb/tb_video_timing_gen_prog.sv
// tb/tb_video_timing_gen_prog.sv - randomized model-checked bench for video_timing_gen_prog
module tb_video_timing_gen_prog;
    localparam int H_W  = 12;
    localparam int V_W  = 11;
    localparam int FPS  = 60;
    localparam int FC_W = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, gl_en, gl;
    int   checks = 0;
    int   failures = 0;

    video_timing_gen_prog_if #(.H_W(H_W), .V_W(V_W)) bus ();
    video_timing_gen_prog_if #(.H_W(H_W), .V_W(V_W)) bus_n ();

    assign bus_n.cfg_h_active_in = bus.cfg_h_active_in;
    assign bus_n.cfg_h_fp_in     = bus.cfg_h_fp_in;
    assign bus_n.cfg_h_sync_in   = bus.cfg_h_sync_in;
    assign bus_n.cfg_h_bp_in     = bus.cfg_h_bp_in;
    assign bus_n.cfg_v_active_in = bus.cfg_v_active_in;
    assign bus_n.cfg_v_fp_in     = bus.cfg_v_fp_in;
    assign bus_n.cfg_v_sync_in   = bus.cfg_v_sync_in;
    assign bus_n.cfg_v_bp_in     = bus.cfg_v_bp_in;
    assign bus_n.cfg_valid_in    = bus.cfg_valid_in;

    logic [H_W-1:0]  hcount, hcount_n;
    logic [V_W-1:0]  vcount, vcount_n;
    logic            hs, vs, ad, nf, lock, hs_n, vs_n, ad_n, nf_n, lock_n;
    logic [FC_W-1:0] fc, fc_n;

    video_timing_gen_prog dut (
        .pixel_clk_in(clk), .rst_in(rst), .cfg(bus),
        .genlock_en_in(gl_en), .genlock_in(gl),
        .hcount_out(hcount), .vcount_out(vcount), .hs_out(hs), .vs_out(vs),
        .ad_out(ad), .nf_out(nf), .fc_out(fc), .lock_out(lock)
    );

    video_timing_gen_prog #(.HS_POL(1'b0), .VS_POL(1'b0)) dut_n (
        .pixel_clk_in(clk), .rst_in(rst), .cfg(bus_n),
        .genlock_en_in(gl_en), .genlock_in(gl),
        .hcount_out(hcount_n), .vcount_out(vcount_n), .hs_out(hs_n), .vs_out(vs_n),
        .ad_out(ad_n), .nf_out(nf_n), .fc_out(fc_n), .lock_out(lock_n)
    );

    // Reference model: raster kept as a linear pixel index within the frame.
    int g[8];
    int pg[8];
    bit pend, fresh, m_lock, m_err;
    int p, m_fc;

    function automatic int htot_m();
        return g[0] + g[1] + g[2] + g[3];
    endfunction

    function automatic int vtot_m();
        return g[4] + g[5] + g[6] + g[7];
    endfunction

    function automatic bit legal_m();
        bit ok = 1'b1;
        for (int k = 0; k < 8; k++) if (pg[k] < 1) ok = 1'b0;
        if (pg[0] + pg[1] + pg[2] + pg[3] > 4096) ok = 1'b0;
        if (pg[4] + pg[5] + pg[6] + pg[7] > 2048) ok = 1'b0;
        return ok;
    endfunction

    function automatic int cur_h();
        return p % htot_m();
    endfunction

    function automatic int cur_v();
        return p / htot_m();
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            g = '{1280, 110, 40, 220, 720, 5, 5, 20};
            pend = 0; p = 0; m_fc = 0; m_lock = 0; m_err = 0; fresh = 1;
        end else begin
            int  total;
            bit  at_end, glk, wrap, had;
            total  = htot_m() * vtot_m();
            at_end = (p == total - 1);
            glk    = gl_en && gl;
            wrap   = at_end || glk;
            had    = pend;
            m_err  = 0;
            if (wrap && pend) begin
                if (legal_m()) g = pg;
                else m_err = 1;
                pend = 0;
            end
            if (bus.cfg_valid_in && !had) begin
                pg[0] = int'(bus.cfg_h_active_in); pg[1] = int'(bus.cfg_h_fp_in);
                pg[2] = int'(bus.cfg_h_sync_in);   pg[3] = int'(bus.cfg_h_bp_in);
                pg[4] = int'(bus.cfg_v_active_in); pg[5] = int'(bus.cfg_v_fp_in);
                pg[6] = int'(bus.cfg_v_sync_in);   pg[7] = int'(bus.cfg_v_bp_in);
                pend = 1;
            end
            if (!gl_en) m_lock = 0;
            else if (glk) m_lock = at_end;
            if (wrap) begin
                p = 0;
                m_fc = (m_fc + 1) % FPS;
            end else begin
                p++;
            end
            fresh = 0;
        end
    end

    function automatic logic [37:0] exp_vec();
        int h, v;
        logic hs_e, vs_e, ad_e, nf_e;
        h = cur_h();
        v = cur_v();
        hs_e = (h >= g[0] + g[1]) && (h < g[0] + g[1] + g[2]);
        vs_e = (v >= g[4] + g[5]) && (v < g[4] + g[5] + g[6]);
        ad_e = !fresh && (h < g[0]) && (v < g[4]);
        nf_e = (h == g[0]) && (v == g[4]);
        return {h[11:0], v[10:0], hs_e, vs_e, ad_e, nf_e, m_fc[5:0], m_lock, !pend, m_err, !hs_e, !vs_e};
    endfunction

    function automatic logic [37:0] act_vec();
        return {hcount, vcount, hs, vs, ad, nf, fc, lock, bus.cfg_ready_out, bus.cfg_err_out, hs_n, vs_n};
    endfunction

    localparam logic [37:0] RESET_VEC = {12'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_cfg(input int ha, hf, hsy, hb, va, vf, vsy, vb);
        bus.cfg_h_active_in = H_W'(ha); bus.cfg_h_fp_in = H_W'(hf);
        bus.cfg_h_sync_in   = H_W'(hsy); bus.cfg_h_bp_in = H_W'(hb);
        bus.cfg_v_active_in = V_W'(va); bus.cfg_v_fp_in = V_W'(vf);
        bus.cfg_v_sync_in   = V_W'(vsy); bus.cfg_v_bp_in = V_W'(vb);
    endtask

    task automatic do_reset();
        rst = 1; gl_en = 0; gl = 0; bus.cfg_valid_in = 0;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; gl_en = 0; gl = 0; bus.cfg_valid_in = 0;
        set_cfg(1, 1, 1, 1, 1, 1, 1, 1);
        tick();
        checks++;
        if (act_vec() !== RESET_VEC) begin
            failures++; $display("FAIL reset_state got=%h exp=%h", act_vec(), RESET_VEC);
        end
        rst = 0;
        checks++;
        if (act_vec() !== RESET_VEC) begin
            failures++; $display("FAIL first_cycle_after_release got=%h exp=%h", act_vec(), RESET_VEC);
        end
        tick();
        checks++;
        if ({hcount, vcount, ad} !== {12'd1, 11'd0, 1'b1}) begin
            failures++; $display("FAIL second_cycle got=%0d,%0d,%b exp=1,0,1", hcount, vcount, ad);
        end
    endtask

    task automatic test_default_line();
        int first_hs = -1;
        int n_hs = 0;
        do_reset();
        for (int i = 0; i < 1700; i++) begin
            tick();
            if (vcount == 0 && hs) begin
                n_hs++;
                if (first_hs < 0) first_hs = int'(hcount);
            end
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++; $display("FAIL default_line cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
            end
        end
        checks++;
        if (first_hs != 1390 || n_hs != 40) begin
            failures++; $display("FAIL default_hsync got=start %0d len %0d exp=start 1390 len 40", first_hs, n_hs);
        end
    endtask

    task automatic test_bad_config();
        do_reset();
        set_cfg(1280, 110, 0, 220, 720, 5, 5, 20);
        bus.cfg_valid_in = 1;
        tick();
        bus.cfg_valid_in = 0;
        checks++;
        if (bus.cfg_ready_out !== 1'b0) begin
            failures++; $display("FAIL bad_cfg_ready_low got=%b exp=0", bus.cfg_ready_out);
        end
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++; $display("FAIL bad_cfg_wait cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
            end
        end
        gl_en = 1; gl = 1;
        tick();
        gl = 0;
        checks++;
        if ({bus.cfg_err_out, bus.cfg_ready_out, hcount, vcount} !== {1'b1, 1'b1, 12'd0, 11'd0}) begin
            failures++; $display("FAIL bad_cfg_err_pulse got=err %b rdy %b pos %0d,%0d exp=err 1 rdy 1 pos 0,0",
                                 bus.cfg_err_out, bus.cfg_ready_out, hcount, vcount);
        end
        tick();
        checks++;
        if (bus.cfg_err_out !== 1'b0) begin
            failures++; $display("FAIL bad_cfg_err_one_cycle got=%b exp=0", bus.cfg_err_out);
        end
        for (int i = 0; i < 1700; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++; $display("FAIL bad_cfg_after cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
            end
        end
        gl_en = 0;
    endtask

    task automatic test_small_config();
        int n_ad, n_nf, n_err;
        do_reset();
        set_cfg(8, 2, 2, 2, 4, 1, 1, 1);
        bus.cfg_valid_in = 1;
        tick();
        bus.cfg_valid_in = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec() || bus.cfg_ready_out !== 1'b0) begin
                failures++; $display("FAIL small_pending cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
            end
        end
        gl_en = 1; gl = 1;
        tick();
        gl = 0; gl_en = 0;
        for (int f = 0; f < 3; f++) begin
            n_ad = 0; n_nf = 0; n_err = 0;
            for (int c = 0; c < 98; c++) begin
                n_ad += int'(ad);
                n_nf += int'(nf);
                n_err += int'(bus.cfg_err_out);
                tick();
                checks++;
                if (act_vec() !== exp_vec()) begin
                    failures++; $display("FAIL small_frame f=%0d c=%0d got=%h exp=%h", f, c, act_vec(), exp_vec());
                end
            end
            checks++;
            if (n_ad != 32 || n_nf != 1 || n_err != 0) begin
                failures++; $display("FAIL small_frame_counts f=%0d got=ad %0d nf %0d err %0d exp=ad 32 nf 1 err 0",
                                     f, n_ad, n_nf, n_err);
            end
        end
    endtask

    task automatic test_genlock();
        int fc_exp;
        bit found;
        gl_en = 1;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (cur_h() == 5 && cur_v() == 3) found = 1;
            else tick();
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL genlock_seek got=timeout exp=position 5,3");
        end
        fc_exp = (m_fc + 1) % FPS;
        gl = 1;
        tick();
        gl = 0;
        checks++;
        if ({hcount, vcount, fc, lock} !== {12'd0, 11'd0, 6'(fc_exp), 1'b0}) begin
            failures++; $display("FAIL genlock_forced got=%0d,%0d fc %0d lock %b exp=0,0 fc %0d lock 0",
                                 hcount, vcount, fc, lock, fc_exp);
        end
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 200 && !(cur_h() == 13 && cur_v() == 6); i++) tick();
            fc_exp = (m_fc + 1) % FPS;
            gl = 1;
            tick();
            gl = 0;
            checks++;
            if ({hcount, vcount, fc, lock} !== {12'd0, 11'd0, 6'(fc_exp), 1'b1}) begin
                failures++; $display("FAIL genlock_natural w=%0d got=%0d,%0d fc %0d lock %b exp=0,0 fc %0d lock 1",
                                     w, hcount, vcount, fc, lock, fc_exp);
            end
        end
        gl_en = 0;
        tick();
        checks++;
        if (lock !== 1'b0) begin
            failures++; $display("FAIL genlock_disable got=%b exp=0", lock);
        end
    endtask

    task automatic test_random();
        int f[8];
        do_reset();
        gl_en = 1;
        for (int i = 0; i < 20000; i++) begin
            bus.cfg_valid_in = ($urandom_range(0, 19) == 0);
            if (bus.cfg_valid_in) begin
                for (int k = 0; k < 8; k++) f[k] = int'($urandom_range(1, 5));
                if ($urandom_range(0, 7) == 0) f[$urandom_range(0, 7)] = 0;
                set_cfg(f[0], f[1], f[2], f[3], f[4], f[5], f[6], f[7]);
            end
            gl = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 499) == 0) gl_en = ~gl_en;
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
            end
        end
        gl = 0; gl_en = 0; bus.cfg_valid_in = 0;
    endtask

    task automatic test_boundary();
        do_reset();
        set_cfg(4000, 32, 32, 32, 1, 1, 1, 1);
        bus.cfg_valid_in = 1;
        tick();
        bus.cfg_valid_in = 0;
        gl_en = 1; gl = 1;
        tick();
        gl = 0; gl_en = 0;
        for (int i = 0; i < 4 * 4096 + 20; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++; $display("FAIL boundary_4096 cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
            end
        end
        set_cfg(4000, 32, 32, 33, 1, 1, 1, 1);
        bus.cfg_valid_in = 1;
        tick();
        bus.cfg_valid_in = 0;
        gl_en = 1; gl = 1;
        tick();
        gl = 0; gl_en = 0;
        checks++;
        if (bus.cfg_err_out !== 1'b1) begin
            failures++; $display("FAIL boundary_4097_err got=%b exp=1", bus.cfg_err_out);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_cfg(8, 2, 2, 2, 4, 1, 1, 1);
        bus.cfg_valid_in = 1;
        tick();
        bus.cfg_valid_in = 0;
        for (int i = 0; i < 777; i++) tick();
        rst = 1;
        tick();
        checks++;
        if (act_vec() !== RESET_VEC) begin
            failures++; $display("FAIL reset_mid got=%h exp=%h", act_vec(), RESET_VEC);
        end
        rst = 0;
        for (int i = 0; i < 1700; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++; $display("FAIL reset_mid_after cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1; gl_en = 0; gl = 0; bus.cfg_valid_in = 0;
        set_cfg(1, 1, 1, 1, 1, 1, 1, 1);
        test_reset();
        test_default_line();
        test_bad_config();
        test_small_config();
        test_genlock();
        test_random();
        test_boundary();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
